// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - shared parameters, requester indices and broadcast message type for the CDB arbiter
package cdb_pkg;
    localparam int NREQ   = 3;
    localparam int TAG_W  = 3;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;
    localparam int PTR_W  = 2;

    localparam int REQ_ADD = 0;
    localparam int REQ_LW  = 1;
    localparam int REQ_BNE = 2;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_msg_t;
endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - requester/broadcast bundle between execution units and the CDB arbiter
// master: drives req_valid/req_tag/req_data, cdb_stall, flush; sees req_ready, cdb_*, conflict_cnt
// slave : the arbiter side, directions reversed
interface cdb_arbiter_if #(
    parameter int CNT_W = cdb_pkg::CNT_W
);
    import cdb_pkg::*;

    logic [NREQ-1:0]        req_valid;
    logic [NREQ*TAG_W-1:0]  req_tag;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   cdb_stall;
    logic                   flush;
    logic                   cdb_valid;
    logic [TAG_W-1:0]       cdb_tag;
    logic [DATA_W-1:0]      cdb_data;
    logic [CNT_W-1:0]       conflict_cnt;

    modport master (
        output req_valid, req_tag, req_data, cdb_stall, flush,
        input  req_ready, cdb_valid, cdb_tag, cdb_data, conflict_cnt
    );

    modport slave (
        input  req_valid, req_tag, req_data, cdb_stall, flush,
        output req_ready, cdb_valid, cdb_tag, cdb_data, conflict_cnt
    );
endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// rtl/cdb_arbiter_rr_pick.sv - combinational round-robin picker
// req : request vector, ptr : first index to scan
// gnt : one-hot winner (zero when no request), idx : encoded winner, any : a winner exists
module rr_pick
    import cdb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [PTR_W-1:0] idx,
    output logic             any
);
    logic [PTR_W-1:0] pos;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = '0;
        // Scan ptr, ptr+1, ... modulo NREQ; the first set bit wins.
        for (int k = 0; k < NREQ; k++) begin
            pos = PTR_W'((int'(ptr) + k) % NREQ);
            if (!any && req[pos]) begin
                gnt[pos] = 1'b1;
                idx      = pos;
                any      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common data bus arbiter with registered broadcast
// clock, rst_n : clock and synchronous active-low reset
// bus (slave)  : unit requests in, one-hot req_ready out, stall/flush in,
//                registered cdb_valid/cdb_tag/cdb_data and saturating conflict_cnt out
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int CNT_W = cdb_pkg::CNT_W
) (
    input  logic         clock,
    input  logic         rst_n,
    cdb_arbiter_if.slave bus
);
    logic [PTR_W-1:0] rr_ptr;
    cdb_msg_t         cdb_q;
    logic [CNT_W-1:0] cnt_q;

    logic             grant_en;
    logic [NREQ-1:0]  pick_req;
    logic [NREQ-1:0]  gnt;
    logic [PTR_W-1:0] win;
    logic             any;
    logic             conflict;
    logic [TAG_W-1:0] win_tag;
    logic [DATA_W-1:0] win_data;

    // Flush beats stall beats grant; reset also suppresses grants.
    assign grant_en = rst_n && !bus.flush && !bus.cdb_stall;
    assign pick_req = bus.req_valid & {NREQ{grant_en}};

    rr_pick u_pick (
        .req (pick_req),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (win),
        .any (any)
    );

    assign win_tag  = bus.req_tag[int'(win)*TAG_W +: TAG_W];
    assign win_data = bus.req_data[int'(win)*DATA_W +: DATA_W];
    assign conflict = $countones(bus.req_valid) >= 2;

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            cdb_q  <= '0;
            rr_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (bus.flush) begin
                cdb_q.valid <= 1'b0;
            end else if (!bus.cdb_stall) begin
                if (any) begin
                    cdb_q.valid <= 1'b1;
                    cdb_q.tag   <= win_tag;
                    cdb_q.data  <= win_data;
                    rr_ptr      <= (win == PTR_W'(NREQ-1)) ? '0 : win + 1'b1;
                end else begin
                    // Tag and data keep their last value; only valid drops.
                    cdb_q.valid <= 1'b0;
                end
            end
            // Counts regardless of stall/flush, saturating at all-ones.
            if (conflict && cnt_q != {CNT_W{1'b1}}) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.req_ready    = gnt;
    assign bus.cdb_valid    = cdb_q.valid;
    assign bus.cdb_tag      = cdb_q.tag;
    assign bus.cdb_data     = cdb_q.data;
    assign bus.conflict_cnt = cnt_q;
endmodule
